// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_write_arbiter_if
//  Purpose  : Bundle of writeback-port signals: pipeline write request,
//             long-latency result handshake, register-file write port,
//             stall request and pending-write bitmap.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_write_arbiter_if;
    logic        p_we;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic        d_valid;
    logic        d_ready;
    logic [4:0]  d_waddr;
    logic [31:0] d_wdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall_req;
    logic [31:0] pend;

    // Producer side: pipeline and long-latency units
    modport master (
        output p_we, p_waddr, p_wdata, d_valid, d_waddr, d_wdata,
        input  d_ready, we, waddr, wdata, stall_req, pend
    );

    // Arbiter side
    modport slave (
        input  p_we, p_waddr, p_wdata, d_valid, d_waddr, d_wdata,
        output d_ready, we, waddr, wdata, stall_req, pend
    );
endinterface
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_write_arbiter
//  Purpose  : Merges in-order pipeline writes and buffered long-latency
//             results onto the single register-file write port. Buffered
//             results drain when the pipeline leaves the port idle; a head
//             that waits STARVE_LIMIT cycles raises stall_req to force a pop.
//  Options  : WB_SCOREBOARD_EN - drive pend with the set of registers that
//             have a buffered write; otherwise pend is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module wb_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,     // asynchronous, active-low
    wb_write_arbiter_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] c_last  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [3:0]    c_limit = 4'(STARVE_LIMIT);

    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_age;
    logic          r_we;
    logic [4:0]    r_waddr;
    logic [31:0]   r_wdata;

    logic w_empty;
    logic w_ready;
    logic w_stall;
    logic w_p_ok;
    logic w_push;
    logic w_pop;
    logic w_sel_pipe;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (r_count == '0);
    assign w_ready = (r_count < c_depth);
    assign w_stall = !w_empty && (r_age == c_limit);
    // A pipeline write to r0 is treated as an idle slot
    assign w_p_ok  = bus.p_we && (bus.p_waddr != 5'd0);
    // r0 results complete the handshake but are dropped
    assign w_push  = bus.d_valid && w_ready && (bus.d_waddr != 5'd0);

    // Port arbitration: forced pop, then pipeline, then opportunistic pop
    always_comb begin
        w_pop      = 1'b0;
        w_sel_pipe = 1'b0;
        if (w_stall) begin
            w_pop = 1'b1;
        end else if (w_p_ok) begin
            w_sel_pipe = 1'b1;
        end else if (!w_empty) begin
            w_pop = 1'b1;
        end
    end

    // FIFO payload storage; contents are qualified by count, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= bus.d_waddr;
            r_data[r_wr_ptr] <= bus.d_wdata;
        end
    end

    // FIFO pointers, occupancy and head age
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_age    <= 4'd0;
        end else begin
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_empty || w_pop) begin
                r_age <= 4'd0;
            end else if (r_age != c_limit) begin
                r_age <= r_age + 4'd1;
            end
        end
    end

    // Registered write port; address/data hold while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 32'd0;
        end else begin
            r_we <= w_pop || w_sel_pipe;
            if (w_pop) begin
                r_waddr <= r_addr[r_rd_ptr];
                r_wdata <= r_data[r_rd_ptr];
            end else if (w_sel_pipe) begin
                r_waddr <= bus.p_waddr;
                r_wdata <= bus.p_wdata;
            end
        end
    end

    assign bus.d_ready   = w_ready;
    assign bus.we        = r_we;
    assign bus.waddr     = r_waddr;
    assign bus.wdata     = r_wdata;
    assign bus.stall_req = w_stall;

`ifdef WB_SCOREBOARD_EN
    logic [DEPTH-1:0] r_vld;
    logic [31:0]      w_pend;

    // Per-slot valid bits; push and pop never hit the same slot in one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
        end else begin
            if (w_pop)  r_vld[r_rd_ptr] <= 1'b0;
            if (w_push) r_vld[r_wr_ptr] <= 1'b1;
        end
    end

    // Decode buffered destinations into the pending bitmap
    always_comb begin
        w_pend = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) w_pend[r_addr[i]] = 1'b1;
        end
    end

    assign bus.pend = w_pend;
`else
    assign bus.pend = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_write_arbiter
//  Purpose  : Self-checking bench for wb_write_arbiter with a queue-based
//             reference of the FIFO/age behaviour and a write scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_write_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wb_write_arbiter_if bus();

    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    ent_t        mq[$];
    ent_t        sb_q[$];
    int          m_age   = 0;
    logic [4:0]  m_last_a = '0;
    logic [31:0] m_last_d = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_pend();
        logic [31:0] p;
        p = 32'h0;
`ifdef WB_SCOREBOARD_EN
        foreach (mq[i]) p[mq[i].a] = 1'b1;
`endif
        return p;
    endfunction

    task automatic m_reset();
        mq.delete();
        sb_q.delete();
        m_age    = 0;
        m_last_a = '0;
        m_last_d = '0;
    endtask

    task automatic set_idle();
        bus.p_we    = 1'b0;
        bus.p_waddr = '0;
        bus.p_wdata = '0;
        bus.d_valid = 1'b0;
        bus.d_waddr = '0;
        bus.d_wdata = '0;
    endtask

    // One clock: check registered outputs, predict, advance, check write port
    task automatic tick(output bit stalled);
        bit   was_empty, m_ready, pop, push, exp_we;
        ent_t e, x;
        was_empty = (mq.size() == 0);
        m_ready   = (mq.size() < DEPTH);
        stalled   = !was_empty && (m_age == LIMIT);
        chk("d_ready", {31'd0, bus.d_ready}, {31'd0, m_ready});
        chk("stall_req", {31'd0, bus.stall_req}, {31'd0, stalled});
        chk("pend", bus.pend, m_pend());
        pop = 1'b0;
        if (stalled) begin
            pop = 1'b1;
            sb_q.push_back(mq[0]);
        end else if (bus.p_we && bus.p_waddr != 5'd0) begin
            sb_q.push_back({bus.p_waddr, bus.p_wdata});
        end else if (!was_empty) begin
            pop = 1'b1;
            sb_q.push_back(mq[0]);
        end
        push = bus.d_valid && m_ready && (bus.d_waddr != 5'd0);
        e    = {bus.d_waddr, bus.d_wdata};
        @(posedge clk);
        #1;
        if (pop) x = mq.pop_front();
        if (push) mq.push_back(e);
        if (was_empty || pop) m_age = 0;
        else if (m_age < LIMIT) m_age++;
        exp_we = (sb_q.size() != 0);
        chk("we", {31'd0, bus.we}, {31'd0, exp_we});
        if (exp_we) begin
            x = sb_q.pop_front();
            chk("waddr", {27'd0, bus.waddr}, {27'd0, x.a});
            chk("wdata", bus.wdata, x.d);
            m_last_a = x.a;
            m_last_d = x.d;
        end else begin
            chk("waddr_hold", {27'd0, bus.waddr}, {27'd0, m_last_a});
            chk("wdata_hold", bus.wdata, m_last_d);
        end
        chk("no_r0_write", {31'd0, (bus.we && bus.waddr == 5'd0)}, 32'd0);
    endtask

    initial begin
        bit st;
        int i, cyc, cnt;

        // Reset held with active-looking inputs
        bus.p_we = 1'b1; bus.p_waddr = 5'd7; bus.p_wdata = 32'h7777_7777;
        bus.d_valid = 1'b1; bus.d_waddr = 5'd9; bus.d_wdata = 32'h9999_9999;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", {31'd0, bus.we}, 32'd0);
        chk("rst_waddr", {27'd0, bus.waddr}, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
        chk("rst_pend", bus.pend, 32'd0);
        set_idle();
        rst = 1'b1;
        chk("rst_ready", {31'd0, bus.d_ready}, 32'd1);
        tick(st);

        // Idle-port drain
        bus.d_valid = 1'b1; bus.d_waddr = 5'd5; bus.d_wdata = 32'hDEAD_BEEF;
        tick(st);
        set_idle();
        tick(st);
        chk("drain_we", {31'd0, bus.we}, 32'd1);
        chk("drain_addr", {27'd0, bus.waddr}, 32'd5);
        chk("drain_data", bus.wdata, 32'hDEAD_BEEF);
        tick(st);

        // Pipeline priority, full FIFO, starvation interleave
        i = 1; cyc = 0;
        while (i <= 7 && cyc < 40) begin
            bus.p_we = 1'b1; bus.p_waddr = 5'(i); bus.p_wdata = 32'h1000 + i;
            bus.d_valid = (cyc < 2);
            bus.d_waddr = (cyc == 0) ? 5'd8 : 5'd9;
            bus.d_wdata = (cyc == 0) ? 32'h8888 : 32'h9999;
            tick(st);
            if (cyc == 1) chk("full_ready", {31'd0, bus.d_ready}, 32'd0);
            if (!st) i++;
            cyc++;
        end
        chk("pipe_bound", (cyc < 40) ? 32'd1 : 32'd0, 32'd1);
        set_idle();
        repeat (4) tick(st);

        // Starvation with pipeline held busy
        bus.p_we = 1'b1; bus.p_waddr = 5'd11; bus.p_wdata = 32'hB0B0_0011;
        bus.d_valid = 1'b1; bus.d_waddr = 5'd10; bus.d_wdata = 32'hA0A0_0010;
        tick(st);
        bus.d_valid = 1'b0;
        cnt = 0;
        while (!bus.stall_req && cnt < 20) begin
            tick(st);
            cnt++;
        end
        chk("starve_wait", cnt, 32'd4);
        tick(st);
        chk("starve_issue", {27'd0, bus.waddr}, 32'd10);
        chk("starve_clear", {31'd0, bus.stall_req}, 32'd0);
        tick(st);
        chk("starve_deferred", {27'd0, bus.waddr}, 32'd11);
        set_idle();
        repeat (2) tick(st);

        // r0 writes
        bus.p_we = 1'b1; bus.p_waddr = 5'd12; bus.p_wdata = 32'hC;
        bus.d_valid = 1'b1; bus.d_waddr = 5'd3; bus.d_wdata = 32'h333;
        tick(st);
        bus.p_waddr = 5'd0; bus.p_wdata = 32'hBAD0;
        bus.d_waddr = 5'd0; bus.d_wdata = 32'hBAD1;
        tick(st);
        chk("r0_issue", {27'd0, bus.waddr}, 32'd3);
        chk("r0_ready", {31'd0, bus.d_ready}, 32'd1);
        set_idle();
        repeat (2) tick(st);

        // Mid-operation reset with two entries buffered
        bus.p_we = 1'b1; bus.p_waddr = 5'd13; bus.p_wdata = 32'hD;
        bus.d_valid = 1'b1; bus.d_waddr = 5'd14; bus.d_wdata = 32'hE;
        tick(st);
        bus.d_waddr = 5'd15; bus.d_wdata = 32'hF;
        tick(st);
        chk("pre_rst_ready", {31'd0, bus.d_ready}, 32'd0);
        set_idle();
        rst = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        chk("mid_rst_we", {31'd0, bus.we}, 32'd0);
        chk("mid_rst_pend", bus.pend, 32'd0);
        rst = 1'b1;
        repeat (4) tick(st);

        // Random traffic
        for (int k = 0; k < 80; k++) begin
            bus.p_we    = $urandom_range(0, 1);
            bus.p_waddr = 5'($urandom_range(0, 31));
            bus.p_wdata = $urandom;
            bus.d_valid = $urandom_range(0, 1);
            bus.d_waddr = 5'($urandom_range(0, 31));
            bus.d_wdata = $urandom;
            tick(st);
        end
        set_idle();
        repeat (LIMIT + DEPTH + 2) tick(st);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback-side producer for the 32x32 general register file's single write port.
- Merges two write sources onto that port: in-order pipeline results from the MEM/WB register, and out-of-order results from long-latency units (divider) delivered over a valid/ready handshake.
- Long-latency results are buffered in a small FIFO and issued when the pipeline leaves the port idle.
- A starvation guard forces a pipeline bubble if buffered results wait too long.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (1..8).
- STARVE_LIMIT, 4, cycles a FIFO head may wait before stall_req asserts (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- p_we  in  1  pipeline write request.
- p_waddr  in  5  pipeline destination register.
- p_wdata  in  32  pipeline write data.
- d_valid  in  1  long-latency result valid.
- d_ready  out  1  FIFO can accept a result.
- d_waddr  in  5  long-latency destination register.
- d_wdata  in  32  long-latency write data.
- we  out  1  register-file write enable (registered).
- waddr  out  5  register-file write address (registered).
- wdata  out  32  register-file write data (registered).
- stall_req  out  1  request to the pipeline controller for one writeback bubble.
- pend  out  32  bitmap of registers with a buffered, not yet issued write.

Behaviour:
- Reset (rst=0, asynchronous):
  - we=0, waddr=0, wdata=0.
  - FIFO count=0, head age=0, stall_req=0, pend=0.
  - d_ready=1 once rst deasserts.
- Handshake:
  - d_ready = (count < DEPTH). It depends on count only, so there is no push-through-pop when the FIFO is full.
  - Transfer occurs when d_valid && d_ready at a rising edge.
  - A transfer with d_waddr==0 is accepted and discarded (not enqueued).
- Arbitration, evaluated each cycle; the result is registered onto we/waddr/wdata, giving one-cycle latency:
  1. stall_req=1 and FIFO non-empty: pop head and issue it. p_we is ignored that cycle; upstream holds its write and re-presents it.
  2. Otherwise p_we=1 and p_waddr!=0: issue the pipeline write.
  3. Otherwise FIFO non-empty: pop head and issue it.
  4. Otherwise we=0; waddr/wdata hold their last value.
- Writes to register 0 are never issued. p_we with p_waddr==0 counts as idle, so the FIFO may pop that cycle.
- Simultaneous push and pop (count < DEPTH):
  - Both occur; count is unchanged.
  - If the FIFO was empty, the new entry is not issued the same cycle; it becomes the head next cycle.
- Starvation guard:
  - Head age increments each cycle the FIFO is non-empty and no pop occurs; it saturates at STARVE_LIMIT.
  - Age clears to 0 on any pop or when the FIFO is empty.
  - stall_req = (count != 0) && (age == STARVE_LIMIT), decoded combinationally from registers.
  - stall_req deasserts the cycle after the forced pop unless the new head has already aged out (it has not, since age clears on pop).
- Ordering: the decoder must not issue an instruction whose destination bit is set in pend. The arbiter performs no same-register reordering checks.
- FIFO pointers wrap modulo DEPTH.
- rst asserted mid-operation discards all buffered entries; no write is issued.

Optional Feature:
- WB_SCOREBOARD_EN defined: pend[i]=1 iff any valid FIFO entry targets register i, decoded combinationally from entry addresses and valid bits.
- Not defined: pend is tied to 32'h0; the decoder must instead stall on any outstanding long-latency operation.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 with d_valid=1, p_we=1.
  - Required: we=0, waddr=0, wdata=0, stall_req=0, pend=0. After release, d_ready=1.
- Idle-port drain:
  - Stimulus: push d_waddr=5, d_wdata=32'hDEAD_BEEF with p_we=0.
  - Required: next cycle the FIFO head is r5 and pend[5]=1. The following edge gives we=1, waddr=5, wdata=32'hDEADBEEF, and pend[5]=0 after the pop.
- Pipeline priority and full FIFO:
  - Stimulus: p_we=1 every cycle to r1..r7; push r8 then r9.
  - Required: d_ready=0 after both are buffered, and the pipeline writes appear on consecutive cycles with one-cycle latency.
- Starvation:
  - Stimulus: with STARVE_LIMIT=4 and p_we held continuously, buffer r10.
  - Required: stall_req=1 once the head has waited 4 cycles. The next edge issues r10 (the held pipeline write is deferred), then stall_req=0.
- r0 writes:
  - Stimulus: p_we=1, p_waddr=0 while the FIFO holds r3; also push d_waddr=0.
  - Required: r3 issues, the r0 push is accepted with count unchanged, and no we=1 with waddr=0 ever occurs.
- Mid-operation reset:
  - Stimulus: two entries buffered, then rst pulses low for one cycle.
  - Required: count=0, pend=0, and no further writes issue.
